ks_pwm_out: RTL and testbench

Downstream audio output stage for the Karplus-Strong string voice. It takes signed voice samples through a valid/ready handshake and holds them in a one-entry buffer. Each sample is attenuated, converted to offset binary and played out as a fixed-frequency PWM waveform for an external RC low-pass DAC. A per-frame strobe paces the upstream voice, and a saturating counter records buffer underruns.

---
 rtl/ks_pwm_out.sv | 94 +++++++++
 tb/tb_ks_pwm_out.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_pwm_out.sv
// Audio output stage for the Karplus-Strong voice: a one-entry sample buffer feeding
// a fixed-frame PWM DAC driver, with frame pacing strobe and underrun accounting.
module ks_pwm_out #(
  parameter int DATA_WIDTH = 8,
  parameter int ATTN_WIDTH = 3,
  parameter int URUN_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  mute_i,
  input  logic [ATTN_WIDTH-1:0] attn_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  output logic                  frame_strobe_o,
  output logic                  pwm_o,
  output logic [URUN_WIDTH-1:0] underrun_cnt_o,
  input  logic                  clr_underrun_i
);

  localparam logic [DATA_WIDTH-1:0] MID_DUTY = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] CNT_LAST = {DATA_WIDTH{1'b1}};
  localparam logic [URUN_WIDTH-1:0] URUN_MAX = {URUN_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0]        cnt_reg;
  logic [DATA_WIDTH-1:0]        buf_reg;
  logic [DATA_WIDTH-1:0]        duty_reg;
  logic                         buf_full_reg;
  logic                         pwm_reg;
  logic                         strobe_reg;
  logic [URUN_WIDTH-1:0]        urun_reg;

  logic                         frame_end;
  logic                         xfer;
  logic signed [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]        duty_next;

  assign frame_end      = enable_i & (cnt_reg == CNT_LAST);
  // The buffer frees up on the frame-end edge, so a new sample may land in the same cycle.
  assign sample_ready_o = ~buf_full_reg | frame_end;
  assign xfer           = sample_valid_i & sample_ready_o;

  assign frame_strobe_o = strobe_reg;
  assign pwm_o          = pwm_reg;
  assign underrun_cnt_o = urun_reg;

  // Attenuate, then flip the sign bit to get offset-binary duty.
  always_comb begin
    shifted   = $signed(buf_reg) >>> attn_i;
    duty_next = {~shifted[DATA_WIDTH-1], shifted[DATA_WIDTH-2:0]};
    if (mute_i) begin
      duty_next = MID_DUTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      buf_reg      <= '0;
      duty_reg     <= MID_DUTY;
      buf_full_reg <= 1'b0;
      pwm_reg      <= 1'b0;
      strobe_reg   <= 1'b0;
      urun_reg     <= '0;
    end else begin
      cnt_reg    <= enable_i ? cnt_reg + 1'b1 : '0;
      pwm_reg    <= enable_i & (cnt_reg < duty_reg);
      strobe_reg <= frame_end;

      if (xfer) begin
        buf_reg <= sample_i;
      end

      // duty_next reads the old buffer content, so a same-cycle transfer never skips a sample.
      if (frame_end) begin
        if (buf_full_reg) begin
          duty_reg <= duty_next;
        end else if (mute_i) begin
          duty_reg <= MID_DUTY;
        end
      end

      buf_full_reg <= xfer | (buf_full_reg & ~frame_end);

      if (clr_underrun_i) begin
        urun_reg <= '0;
      end else if (frame_end && !buf_full_reg && (urun_reg != URUN_MAX)) begin
        urun_reg <= urun_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ks_pwm_out.sv
// Directed bench for ks_pwm_out: measures PWM high time per frame against hand-computed
// duties and checks handshake, underrun and reset behaviour.
module tb_ks_pwm_out;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       mute;
  logic [2:0] attn;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       frame_strobe;
  logic       pwm;
  logic [7:0] urun;
  logic       clr;

  int checks = 0;
  int errors = 0;

  ks_pwm_out #(.DATA_WIDTH(8), .ATTN_WIDTH(3), .URUN_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .mute_i         (mute),
    .attn_i         (attn),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .sample_ready_o (sample_ready),
    .frame_strobe_o (frame_strobe),
    .pwm_o          (pwm),
    .underrun_cnt_o (urun),
    .clr_underrun_i (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a negedge where cnt==0 (a strobe point); ends on the next strobe point.
  task automatic run_frame(input logic push, input logic [7:0] s, output int high);
    int strobes;
    high = 0;
    strobes = 0;
    if (push) begin
      sample_valid = 1'b1;
      sample = s;
    end
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (pwm) high++;
      if (frame_strobe) strobes++;
    end
    checks++;
    if (frame_strobe !== 1'b1 || strobes != 1) begin
      errors++;
      $display("FAIL strobe_per_frame: last=%b count=%0d, required last=1 count=1", frame_strobe, strobes);
    end
  endtask

  task automatic check_high(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: high=%0d required=%0d", name, got, exp);
    end else begin
      $display("%s: high=%0d", name, got);
    end
  endtask

  task automatic check_urun(input string name, input int exp);
    checks++;
    if (urun !== 8'(exp)) begin
      errors++;
      $display("FAIL %s: underrun=%0d required=%0d", name, urun, exp);
    end else begin
      $display("%s: underrun=%0d", name, urun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mute = 1'b0; attn = 3'd0;
    sample = 8'h00; sample_valid = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm !== 1'b0 || frame_strobe !== 1'b0 || urun !== 8'd0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: pwm=%b strobe=%b urun=%0d ready=%b, required 0 0 0 1",
               pwm, frame_strobe, urun, sample_ready);
    end else $display("reset_state: ok");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (pwm !== 1'b0 || frame_strobe !== 1'b0 || urun !== 8'd0) begin
        errors++;
        $display("FAIL disabled_idle: pwm=%b strobe=%b urun=%0d, required 0 0 0", pwm, frame_strobe, urun);
      end
    end
    $display("disabled_idle: done");
  endtask

  task automatic test_idle();
    int h;
    enable = 1'b1;
    run_frame(1'b0, 8'h00, h);
    check_high("idle_frame0", h, 128);
    check_urun("idle_urun0", 1);
    run_frame(1'b0, 8'h00, h);
    check_high("idle_frame1", h, 128);
    check_urun("idle_urun1", 2);
  endtask

  task automatic test_duty_extremes();
    int h;
    run_frame(1'b1, 8'h7F, h);
    check_high("ext_prev", h, 128);
    run_frame(1'b1, 8'h80, h);
    check_high("ext_7f", h, 255);
    run_frame(1'b1, 8'h00, h);
    check_high("ext_80", h, 0);
    check_urun("ext_no_underrun", 2);
    run_frame(1'b0, 8'h00, h);
    check_high("ext_00", h, 128);
    check_urun("ext_underrun", 3);
  endtask

  task automatic test_attn();
    int h;
    attn = 3'd2;
    run_frame(1'b1, 8'h60, h);
    attn = 3'd1;
    run_frame(1'b1, 8'hA0, h);
    check_high("attn_60_s2", h, 152);
    run_frame(1'b0, 8'h00, h);
    check_high("attn_a0_s1", h, 80);
    attn = 3'd0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [5];
    int exp_high [4];
    int idx;
    int h;
    logic prev_ready;
    logic exp_ready;
    q[0] = 8'h10; q[1] = 8'hF0; q[2] = 8'h40; q[3] = 8'h20; q[4] = 8'h00;
    exp_high[0] = 0; exp_high[1] = 144; exp_high[2] = 112; exp_high[3] = 192;
    idx = 0;
    sample_valid = 1'b1;
    sample = q[0];
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_empty: ready=%b required=1", sample_ready);
    end
    prev_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      h = 0;
      for (int k = 1; k <= 256; k++) begin
        @(negedge clk);
        if (prev_ready && sample_valid) begin
          idx++;
          if (idx < 5) sample = q[idx];
          else sample_valid = 1'b0;
        end
        if (pwm) h++;
        exp_ready = (k == 255);
        checks++;
        if (sample_ready !== exp_ready) begin
          errors++;
          $display("FAIL b2b_ready: frame=%0d cnt=%0d ready=%b required=%b", f, k % 256, sample_ready, exp_ready);
        end
        prev_ready = sample_ready;
      end
      if (f > 0) check_high("b2b_frame", h, exp_high[f]);
    end
    sample_valid = 1'b0;
    run_frame(1'b0, 8'h00, h);
    check_high("b2b_drain_q3", h, 160);
    run_frame(1'b0, 8'h00, h);
    check_high("b2b_drain_q4", h, 128);
  endtask

  task automatic test_late_sample();
    int u0;
    int h;
    u0 = int'(urun);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 255) begin
        sample_valid = 1'b1;
        sample = 8'h7F;
        checks++;
        if (sample_ready !== 1'b1) begin
          errors++;
          $display("FAIL late_ready: ready=%b required=1", sample_ready);
        end
      end
      if (k == 256) sample_valid = 1'b0;
    end
    check_urun("late_underrun", u0 + 1);
    run_frame(1'b0, 8'h00, h);
    check_high("late_repeat", h, 128);
    run_frame(1'b0, 8'h00, h);
    check_high("late_play", h, 255);
  endtask

  task automatic test_saturate_clear();
    int h;
    repeat (300 * 256) @(negedge clk);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 254) check_urun("urun_saturated", 255);
      if (k == 255) clr = 1'b1;
      if (k == 256) clr = 1'b0;
    end
    check_urun("clr_priority", 0);
    run_frame(1'b0, 8'h00, h);
    check_urun("urun_after_clr", 1);
  endtask

  task automatic test_mute();
    int h;
    int u;
    mute = 1'b1;
    run_frame(1'b1, 8'h7F, h);
    mute = 1'b0;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL mute_drained_ready: ready=%b required=1", sample_ready);
    end
    u = int'(urun);
    run_frame(1'b0, 8'h00, h);
    check_high("mute_frame", h, 128);
    check_urun("mute_drained_urun", u + 1);
  endtask

  task automatic test_reset_midframe();
    int h;
    sample_valid = 1'b1;
    sample = 8'h7F;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
    checks++;
    if (pwm !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pwm_before: pwm=%b required=1", pwm);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== 1'b0 || frame_strobe !== 1'b0 || urun !== 8'd0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: pwm=%b strobe=%b urun=%0d ready=%b, required 0 0 0 1",
               pwm, frame_strobe, urun, sample_ready);
    end else $display("midframe_reset: ok");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 8'h00, h);
    check_high("post_reset_frame0", h, 128);
    check_urun("post_reset_urun0", 1);
    run_frame(1'b0, 8'h00, h);
    check_high("post_reset_frame1", h, 128);
    check_urun("post_reset_urun1", 2);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_duty_extremes();
    test_attn();
    test_back_to_back();
    test_late_sample();
    test_saturate_clear();
    test_mute();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
